// File: rtl/window_map_gen_pkg.sv
// ---------------------------------------------------------------------------
// window_map_gen_pkg
// Shared video definitions for the window tile-map address generator:
//   win_state_t  - window sequencing states
//   DEF_BASE0/1  - default tile-map base addresses (map_sel = 0 / 1)
// ---------------------------------------------------------------------------
package window_map_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,   // no y-hit this frame
      ARMED  = 2'd1,   // y-hit seen, waiting for the x match
      ACTIVE = 2'd2,   // window owns pixels and fetches tiles
      DONE   = 2'd3    // window ended or disabled for the rest of the line
   } win_state_t;

   localparam logic [12:0] DEF_BASE0 = 13'h1800;
   localparam logic [12:0] DEF_BASE1 = 13'h1C00;

endpackage

// File: rtl/window_addr_calc.sv
// ---------------------------------------------------------------------------
// window_addr_calc
// Combinational tile-map address composition and column advance.
//   map_sel     in  : selects BASE1 (1) or BASE0 (0)
//   row_raw     in  : window line / 8 (before vertical wrap)
//   tile_x      in  : current column
//   map_addr    out : base + (row << MAP_W_LOG2) + tile_x, ADDR_W bits
//   tile_x_next out : column after an ack (wraps, or saturates when CLAMP=1)
// ---------------------------------------------------------------------------
module window_addr_calc
   import window_map_gen_pkg::*;
#(
   parameter int                MAP_W_LOG2 = 5,
   parameter int                MAP_H_LOG2 = 5,
   parameter int                ADDR_W     = 13,
   parameter logic [ADDR_W-1:0] BASE0      = ADDR_W'(DEF_BASE0),
   parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(DEF_BASE1),
   parameter bit                CLAMP      = 1'b0
)(
   input  logic                  map_sel,
   input  logic [4:0]            row_raw,
   input  logic [MAP_W_LOG2-1:0] tile_x,
   output logic [ADDR_W-1:0]     map_addr,
   output logic [MAP_W_LOG2-1:0] tile_x_next
);

   logic [31:0]       row;
   logic [ADDR_W-1:0] base;

   always_comb begin
      // Vertical wrap: keep only MAP_H_LOG2 bits of the row index.
      row      = 32'(row_raw) & ((32'd1 << MAP_H_LOG2) - 32'd1);
      base     = map_sel ? BASE1 : BASE0;
      map_addr = base + ADDR_W'(row << MAP_W_LOG2) + ADDR_W'(tile_x);

      if (tile_x == {MAP_W_LOG2{1'b1}})
         tile_x_next = CLAMP ? tile_x : '0;
      else
         tile_x_next = tile_x + MAP_W_LOG2'(1);
   end

endmodule

// File: rtl/window_map_gen.sv
// ---------------------------------------------------------------------------
// window_map_gen
// Window sequencer: detects the window's y/x start, counts window lines and
// issues tile-map addresses to the background fetcher.
//   clk2, reset_video2     : video clock, synchronous active-high reset
//   frame_start/line_start : vblank-end and line-begin pulses
//   px_valid, ly, px       : pixel advance strobe, current line and pixel x
//   win_en, wy, wx         : window enable and position
//   map_sel, fetch_req     : map base select, fetcher address request
//   win_active             : window owns the pixels (ACTIVE state)
//   win_trigger            : one-cycle pulse when the window starts
//   fetch_ack, map_addr    : address strobe and held tile-map address
//   win_fine, tile_x       : fine row inside the tile, current column
// ---------------------------------------------------------------------------
module window_map_gen
   import window_map_gen_pkg::*;
#(
   parameter int                MAP_W_LOG2 = 5,
   parameter int                MAP_H_LOG2 = 5,
   parameter int                ADDR_W     = 13,
   parameter logic [ADDR_W-1:0] BASE0      = ADDR_W'(DEF_BASE0),
   parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(DEF_BASE1),
   parameter int                WX_OFFSET  = 7,
   parameter bit                CLAMP      = 1'b0
)(
   input  logic                  clk2,
   input  logic                  reset_video2,
   input  logic                  frame_start,
   input  logic                  line_start,
   input  logic                  px_valid,
   input  logic [7:0]            ly,
   input  logic [7:0]            px,
   input  logic                  win_en,
   input  logic [7:0]            wy,
   input  logic [7:0]            wx,
   input  logic                  map_sel,
   input  logic                  fetch_req,
   output logic                  win_active,
   output logic                  win_trigger,
   output logic                  fetch_ack,
   output logic [ADDR_W-1:0]     map_addr,
   output logic [2:0]            win_fine,
   output logic [MAP_W_LOG2-1:0] tile_x
);

   win_state_t            state_q, state_d;
   logic                  yhit_q, yhit_set;
   logic                  was_active_q;
   logic [7:0]            win_line_q;
   logic [MAP_W_LOG2-1:0] tile_x_q, tile_x_next;
   logic [8:0]            px_sum;
   logic                  trig_cond, fetch_go;
   logic [ADDR_W-1:0]     addr_p0, addr_p1;
   logic                  vld_p1, trig_p1;

   assign yhit_set = win_en && (ly == wy);
   assign px_sum   = {1'b0, px} + 9'(WX_OFFSET);

   // Line and frame boundaries outrank both the trigger and a fetch, so a
   // request arriving with either is dropped rather than acked.
   assign trig_cond = (state_q == ARMED) && px_valid && win_en &&
                      (px_sum == {1'b0, wx}) && !line_start && !frame_start;
   assign fetch_go  = (state_q == ACTIVE) && fetch_req &&
                      !line_start && !frame_start;

   window_addr_calc #(
      .MAP_W_LOG2 (MAP_W_LOG2),
      .MAP_H_LOG2 (MAP_H_LOG2),
      .ADDR_W     (ADDR_W),
      .BASE0      (BASE0),
      .BASE1      (BASE1),
      .CLAMP      (CLAMP)
   ) u_addr_calc (
      .map_sel     (map_sel),
      .row_raw     (win_line_q[7:3]),
      .tile_x      (tile_x_q),
      .map_addr    (addr_p0),
      .tile_x_next (tile_x_next)
   );

   always_comb begin
      state_d    = state_q;
      win_active = 1'b0;
      if (frame_start) begin
         // A frame boundary that also opens a line may arm immediately.
         state_d = (line_start && (ly == wy)) ? ARMED : IDLE;
      end else if (line_start) begin
         state_d = (yhit_q || yhit_set) ? ARMED : IDLE;
      end else begin
         case (state_q)
            ARMED:   if (trig_cond) state_d = ACTIVE;
            ACTIVE:  if (!win_en)   state_d = DONE;
            default: state_d = state_q;
         endcase
      end
      win_active = (state_q == ACTIVE);
   end

   always_ff @(posedge clk2) begin
      if (reset_video2) begin
         state_q      <= IDLE;
         yhit_q       <= 1'b0;
         was_active_q <= 1'b0;
         win_line_q   <= '0;
         tile_x_q     <= '0;
         addr_p1      <= '0;
         vld_p1       <= 1'b0;
         trig_p1      <= 1'b0;
      end else begin
         state_q <= state_d;
         trig_p1 <= trig_cond;
         vld_p1  <= fetch_go;

         if (frame_start)   yhit_q <= yhit_set;
         else if (yhit_set) yhit_q <= 1'b1;

         // was_active_q remembers ACTIVE anywhere in the current line; the
         // line_start cycle itself still belongs to the previous line.
         if (frame_start) begin
            win_line_q   <= '0;
            was_active_q <= 1'b0;
         end else if (line_start) begin
            if (was_active_q || (state_q == ACTIVE))
               win_line_q <= win_line_q + 8'd1;
            was_active_q <= 1'b0;
         end else if (state_q == ACTIVE) begin
            was_active_q <= 1'b1;
         end

         if (trig_cond)     tile_x_q <= '0;
         else if (fetch_go) tile_x_q <= tile_x_next;

         // ---- stage p0 -> p1: address captured with the req-cycle map_sel
         if (fetch_go) addr_p1 <= addr_p0;
      end
   end

   assign win_trigger = trig_p1;
   assign fetch_ack   = vld_p1;
   assign map_addr    = addr_p1;
   assign win_fine    = win_line_q[2:0];
   assign tile_x      = tile_x_q;

endmodule

// File: tb/tb_window_map_gen.sv
module tb_window_map_gen;

   logic       clk2 = 1'b0;
   logic       reset_video2, frame_start, line_start, px_valid;
   logic [7:0] ly, px, wy, wx;
   logic       win_en, map_sel, fetch_req;

   logic        wa0, wt0, fa0, wa1, wt1, fa1, wa2, wt2, fa2;
   logic [12:0] ma0, ma1, ma2;
   logic [2:0]  wf0, wf1, wf2;
   logic [4:0]  tx0, tx1;
   logic [5:0]  tx2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk2 = ~clk2;

   window_map_gen u_dut0 (
      .clk2(clk2), .reset_video2(reset_video2), .frame_start(frame_start),
      .line_start(line_start), .px_valid(px_valid), .ly(ly), .px(px),
      .win_en(win_en), .wy(wy), .wx(wx), .map_sel(map_sel), .fetch_req(fetch_req),
      .win_active(wa0), .win_trigger(wt0), .fetch_ack(fa0), .map_addr(ma0),
      .win_fine(wf0), .tile_x(tx0));

   window_map_gen #(.CLAMP(1'b1)) u_dut1 (
      .clk2(clk2), .reset_video2(reset_video2), .frame_start(frame_start),
      .line_start(line_start), .px_valid(px_valid), .ly(ly), .px(px),
      .win_en(win_en), .wy(wy), .wx(wx), .map_sel(map_sel), .fetch_req(fetch_req),
      .win_active(wa1), .win_trigger(wt1), .fetch_ack(fa1), .map_addr(ma1),
      .win_fine(wf1), .tile_x(tx1));

   window_map_gen #(.MAP_W_LOG2(6), .MAP_H_LOG2(6)) u_dut2 (
      .clk2(clk2), .reset_video2(reset_video2), .frame_start(frame_start),
      .line_start(line_start), .px_valid(px_valid), .ly(ly), .px(px),
      .win_en(win_en), .wy(wy), .wx(wx), .map_sel(map_sel), .fetch_req(fetch_req),
      .win_active(wa2), .win_trigger(wt2), .fetch_ack(fa2), .map_addr(ma2),
      .win_fine(wf2), .tile_x(tx2));

   // Reference model: behaviour described as "armed / in window" flags,
   // a line count and per-configuration column/address values.
   int          cfg_w [3] = '{5, 5, 6};
   int          cfg_h [3] = '{5, 5, 6};
   bit          cfg_cl[3] = '{1'b0, 1'b1, 1'b0};
   bit          m_yhit, m_armed, m_win, m_had, m_trig, m_ack;
   int          m_line;
   int          m_col [3];
   logic [12:0] m_addr[3];

   task automatic model_edge();
      bit yset, trig, fetch;
      int mx, base;
      if (reset_video2) begin
         m_yhit = 0; m_armed = 0; m_win = 0; m_had = 0; m_trig = 0; m_ack = 0;
         m_line = 0;
         for (int k = 0; k < 3; k++) begin m_col[k] = 0; m_addr[k] = '0; end
         return;
      end
      yset  = win_en && (ly == wy);
      trig  = m_armed && !line_start && !frame_start && px_valid && win_en &&
              (int'(px) + 7 == int'(wx));
      fetch = m_win && fetch_req && !line_start && !frame_start;
      m_trig = trig;
      m_ack  = fetch;
      base   = map_sel ? 'h1C00 : 'h1800;
      for (int k = 0; k < 3; k++) begin
         mx = (1 << cfg_w[k]) - 1;
         if (fetch) begin
            m_addr[k] = 13'((base + ((m_line / 8) % (1 << cfg_h[k])) * (1 << cfg_w[k])
                             + m_col[k]) % 8192);
            if (m_col[k] == mx) m_col[k] = cfg_cl[k] ? mx : 0;
            else                m_col[k] = m_col[k] + 1;
         end
         if (trig) m_col[k] = 0;
      end
      if (frame_start) begin
         m_line = 0; m_had = 0;
      end else if (line_start) begin
         if (m_had || m_win) m_line = (m_line + 1) % 256;
         m_had = 0;
      end else if (m_win) begin
         m_had = 1;
      end
      if (frame_start) begin
         m_armed = line_start && (ly == wy); m_win = 0;
      end else if (line_start) begin
         m_armed = m_yhit || yset; m_win = 0;
      end else if (trig) begin
         m_armed = 0; m_win = 1;
      end else if (m_win && !win_en) begin
         m_win = 0;
      end
      if (frame_start) m_yhit = yset;
      else if (yset)   m_yhit = 1;
   endtask

   task automatic tick();
      @(posedge clk2);
      model_edge();
      #1;
   endtask

   // Stimulus helpers (no checking).
   task automatic pulse_frame();
      frame_start = 1; tick(); frame_start = 0;
   endtask

   task automatic start_window();
      line_start = 1; tick(); line_start = 0;
      px = 8'd0; wx = 8'd7; px_valid = 1; tick(); px_valid = 0; px = 8'd1;
   endtask

   task automatic do_fetch(input logic sel);
      map_sel = sel; fetch_req = 1; tick(); fetch_req = 0;
   endtask

   task automatic test_reset();
      reset_video2 = 1; fetch_req = 1; tick(); tick();
      n_vec++; if (wa0 !== 1'b0) begin n_err++; $display("FAIL rst_active got=%0b exp=0", wa0); end
      n_vec++; if (wt0 !== 1'b0) begin n_err++; $display("FAIL rst_trigger got=%0b exp=0", wt0); end
      n_vec++; if (fa0 !== 1'b0) begin n_err++; $display("FAIL rst_ack got=%0b exp=0", fa0); end
      n_vec++; if (ma0 !== 13'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", ma0); end
      n_vec++; if (wf0 !== 3'd0) begin n_err++; $display("FAIL rst_fine got=%0d exp=0", wf0); end
      n_vec++; if (tx0 !== 5'd0) begin n_err++; $display("FAIL rst_tile_x got=%0d exp=0", tx0); end
      reset_video2 = 0; fetch_req = 0; tick();
   endtask

   task automatic test_basic();
      pulse_frame();
      ly = 8'd16; wy = 8'd16; win_en = 1; tick();
      start_window();
      n_vec++; if (wt0 !== 1'b1) begin n_err++; $display("FAIL basic_trigger got=%0b exp=1", wt0); end
      n_vec++; if (wa0 !== 1'b1) begin n_err++; $display("FAIL basic_active got=%0b exp=1", wa0); end
      n_vec++; if (tx0 !== 5'd0) begin n_err++; $display("FAIL basic_tile_x got=%0d exp=0", tx0); end
      do_fetch(1'b0);
      n_vec++; if (fa0 !== 1'b1) begin n_err++; $display("FAIL basic_ack got=%0b exp=1", fa0); end
      n_vec++; if (ma0 !== 13'h1800) begin n_err++; $display("FAIL basic_addr got=%h exp=1800", ma0); end
      n_vec++; if (wt0 !== 1'b0) begin n_err++; $display("FAIL basic_trig_pulse got=%0b exp=0", wt0); end
      tick();
      n_vec++; if (fa0 !== 1'b0) begin n_err++; $display("FAIL basic_ack_single got=%0b exp=0", fa0); end
      n_vec++; if (ma0 !== 13'h1800) begin n_err++; $display("FAIL basic_addr_hold got=%h exp=1800", ma0); end
      n_vec++; if (tx0 !== 5'd1) begin n_err++; $display("FAIL basic_tile_inc got=%0d exp=1", tx0); end
   endtask

   task automatic test_rows();
      pulse_frame();
      for (int i = 0; i <= 8; i++) begin
         start_window();
         if (i == 4) begin
            do_fetch(1'b1);
            n_vec++; if (wf0 !== 3'd4) begin n_err++; $display("FAIL rows_fine4 got=%0d exp=4", wf0); end
            n_vec++; if (ma0 !== 13'h1C00) begin n_err++; $display("FAIL rows_addr4 got=%h exp=1c00", ma0); end
         end
         if (i == 8) begin
            do_fetch(1'b1);
            n_vec++; if (wf0 !== 3'd0) begin n_err++; $display("FAIL rows_fine8 got=%0d exp=0", wf0); end
            n_vec++; if (ma0 !== 13'h1C20) begin n_err++; $display("FAIL rows_addr8 got=%h exp=1c20", ma0); end
            n_vec++; if (ma1 !== 13'h1C20) begin n_err++; $display("FAIL rows_addr8_clamp got=%h exp=1c20", ma1); end
            n_vec++; if (ma2 !== 13'h1C40) begin n_err++; $display("FAIL rows_addr8_w64 got=%h exp=1c40", ma2); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [12:0] e0, e1;
      pulse_frame();
      start_window();
      map_sel = 0; fetch_req = 1;
      for (int k = 1; k <= 33; k++) begin
         tick();
         e0 = 13'(32'h1800 + (k - 1) % 32);
         e1 = 13'(32'h1800 + ((k - 1) > 31 ? 31 : (k - 1)));
         n_vec++; if (ma0 !== e0) begin n_err++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, ma0, e0); end
         n_vec++; if (ma1 !== e1) begin n_err++; $display("FAIL clamp_addr k=%0d got=%h exp=%h", k, ma1, e1); end
         if (k >= 32) begin
            n_vec++; if (tx0 !== 5'(k % 32)) begin n_err++; $display("FAIL wrap_tile k=%0d got=%0d exp=%0d", k, tx0, k % 32); end
            n_vec++; if (tx1 !== 5'd31) begin n_err++; $display("FAIL clamp_tile k=%0d got=%0d exp=31", k, tx1); end
         end
      end
      fetch_req = 0;
   endtask

   task automatic test_win_drop();
      pulse_frame();
      start_window();
      do_fetch(1'b0);
      win_en = 0; tick(); win_en = 1;
      n_vec++; if (wa0 !== 1'b0) begin n_err++; $display("FAIL drop_active got=%0b exp=0", wa0); end
      px = 8'd0; wx = 8'd7; px_valid = 1; tick(); px_valid = 0;
      n_vec++; if (wt0 !== 1'b0) begin n_err++; $display("FAIL drop_no_retrig got=%0b exp=0", wt0); end
      do_fetch(1'b1);
      n_vec++; if (fa0 !== 1'b0) begin n_err++; $display("FAIL drop_no_ack got=%0b exp=0", fa0); end
      n_vec++; if (ma0 !== 13'h1800) begin n_err++; $display("FAIL drop_addr_kept got=%h exp=1800", ma0); end
      line_start = 1; tick(); line_start = 0;
      n_vec++; if (wf0 !== 3'd1) begin n_err++; $display("FAIL drop_line_inc got=%0d exp=1", wf0); end
   endtask

   task automatic test_coincident();
      pulse_frame();
      line_start = 1; tick();
      px = 8'd0; wx = 8'd7; px_valid = 1; tick();
      n_vec++; if (wt0 !== 1'b0) begin n_err++; $display("FAIL coin_ls_trig got=%0b exp=0", wt0); end
      n_vec++; if (wa0 !== 1'b0) begin n_err++; $display("FAIL coin_ls_active got=%0b exp=0", wa0); end
      line_start = 0; tick(); px_valid = 0;
      n_vec++; if (wt0 !== 1'b1) begin n_err++; $display("FAIL coin_trig_after got=%0b exp=1", wt0); end
      do_fetch(1'b1);
      fetch_req = 1; line_start = 1; tick(); fetch_req = 0; line_start = 0;
      n_vec++; if (fa0 !== 1'b0) begin n_err++; $display("FAIL coin_ack_cancel got=%0b exp=0", fa0); end
      n_vec++; if (ma0 !== 13'h1C00) begin n_err++; $display("FAIL coin_addr_kept got=%h exp=1c00", ma0); end
      n_vec++; if (wf0 !== 3'd1) begin n_err++; $display("FAIL coin_line1 got=%0d exp=1", wf0); end
      frame_start = 1; line_start = 1; tick(); frame_start = 0; line_start = 0;
      n_vec++; if (wf0 !== 3'd0) begin n_err++; $display("FAIL coin_fs_ls_line got=%0d exp=0", wf0); end
      px = 8'd0; px_valid = 1; tick(); px_valid = 0;
      n_vec++; if (wt0 !== 1'b1) begin n_err++; $display("FAIL coin_fs_ls_armed got=%0b exp=1", wt0); end
   endtask

   task automatic test_reset_mid();
      pulse_frame();
      start_window();
      fetch_req = 1; reset_video2 = 1; tick(); reset_video2 = 0;
      n_vec++; if (fa0 !== 1'b0) begin n_err++; $display("FAIL rmid_ack got=%0b exp=0", fa0); end
      n_vec++; if (wa0 !== 1'b0) begin n_err++; $display("FAIL rmid_active got=%0b exp=0", wa0); end
      n_vec++; if (wt0 !== 1'b0) begin n_err++; $display("FAIL rmid_trig got=%0b exp=0", wt0); end
      n_vec++; if (ma0 !== 13'h0) begin n_err++; $display("FAIL rmid_addr got=%h exp=0", ma0); end
      n_vec++; if (tx0 !== 5'd0) begin n_err++; $display("FAIL rmid_tile got=%0d exp=0", tx0); end
      tick(); fetch_req = 0;
      n_vec++; if (fa0 !== 1'b0) begin n_err++; $display("FAIL rmid_idle_ack got=%0b exp=0", fa0); end
      pulse_frame();
      start_window();
      n_vec++; if (wt0 !== 1'b1) begin n_err++; $display("FAIL rmid_restart_trig got=%0b exp=1", wt0); end
      do_fetch(1'b0);
      n_vec++; if (ma0 !== 13'h1800) begin n_err++; $display("FAIL rmid_restart_addr got=%h exp=1800", ma0); end
   endtask

   task automatic test_random();
      logic        wa_a[3], wt_a[3], fa_a[3];
      logic [12:0] ma_a[3];
      logic [2:0]  wf_a[3];
      logic [5:0]  tx_a[3];
      px = 0; ly = 0; wy = 8'd3; win_en = 1;
      for (int c = 0; c < 4000; c++) begin
         reset_video2 = ($urandom_range(0, 999) == 0);
         frame_start  = ($urandom_range(0, 299) == 0);
         line_start   = ($urandom_range(0, 24) == 0);
         px_valid     = 1'($urandom_range(0, 1));
         fetch_req    = 1'($urandom_range(0, 1));
         map_sel      = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 63) == 0) win_en = ~win_en;
         if (frame_start) begin ly = 0; wy = 8'($urandom_range(0, 10)); end
         if (line_start) begin
            px = 0;
            if (!frame_start) ly = ly + 8'd1;
            if ($urandom_range(0, 3) == 0) wx = 8'(7 + $urandom_range(0, 6));
         end
         tick();
         if (px_valid) px = px + 8'd1;
         wa_a = '{wa0, wa1, wa2}; wt_a = '{wt0, wt1, wt2}; fa_a = '{fa0, fa1, fa2};
         ma_a = '{ma0, ma1, ma2}; wf_a = '{wf0, wf1, wf2};
         tx_a = '{{1'b0, tx0}, {1'b0, tx1}, tx2};
         for (int k = 0; k < 3; k++) begin
            n_vec++; if (wa_a[k] !== m_win) begin n_err++; $display("FAIL rnd_active d%0d c=%0d got=%0b exp=%0b", k, c, wa_a[k], m_win); end
            n_vec++; if (wt_a[k] !== m_trig) begin n_err++; $display("FAIL rnd_trigger d%0d c=%0d got=%0b exp=%0b", k, c, wt_a[k], m_trig); end
            n_vec++; if (fa_a[k] !== m_ack) begin n_err++; $display("FAIL rnd_ack d%0d c=%0d got=%0b exp=%0b", k, c, fa_a[k], m_ack); end
            n_vec++; if (ma_a[k] !== m_addr[k]) begin n_err++; $display("FAIL rnd_addr d%0d c=%0d got=%h exp=%h", k, c, ma_a[k], m_addr[k]); end
            n_vec++; if (wf_a[k] !== 3'(m_line % 8)) begin n_err++; $display("FAIL rnd_fine d%0d c=%0d got=%0d exp=%0d", k, c, wf_a[k], m_line % 8); end
            n_vec++; if (tx_a[k] !== 6'(m_col[k])) begin n_err++; $display("FAIL rnd_tile_x d%0d c=%0d got=%0d exp=%0d", k, c, tx_a[k], m_col[k]); end
         end
      end
      reset_video2 = 0; frame_start = 0; line_start = 0; px_valid = 0; fetch_req = 0;
   endtask

   initial begin
      reset_video2 = 1; frame_start = 0; line_start = 0; px_valid = 0;
      ly = 8'd16; wy = 8'd16; px = 0; wx = 8'd7; win_en = 1; map_sel = 0; fetch_req = 0;
      test_reset();
      test_basic();
      test_rows();
      test_wrap();
      test_win_drop();
      test_coincident();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/window_map_gen.md
WINDOW_MAP_GEN -- requirements
Module: window_map_gen

Interface
REQ-001 Parameters SHALL be: MAP_W_LOG2, default 5, log2 of map width in tiles; MAP_H_LOG2, default 5, log2 of map height in tiles; ADDR_W, default 13, map address width; BASE0, default 13'h1800, map base when map_sel=0; BASE1, default 13'h1C00, map base when map_sel=1; WX_OFFSET, default 7, horizontal trigger offset; CLAMP, default 0, where 1 saturates the column and 0 wraps it.
REQ-002 One clock; reset is synchronous and active-high. Ports: clk2 in 1 (video clock, all state on rising edge); reset_video2 in 1 (synchronous active-high reset).
REQ-003 Inputs: frame_start in 1 (vblank-end pulse); line_start in 1 (line-begin pulse); px_valid in 1 (pixel advanced this cycle); ly in 8 (current line); px in 8 (current pixel x); win_en in 1 (window enable); wy in 8 (window y); wx in 8 (window x); map_sel in 1 (map base select); fetch_req in 1 (fetcher requests next tile address).
REQ-004 Outputs: win_active out 1 (window owns pixels); win_trigger out 1 (one-cycle pulse on window start); fetch_ack out 1 (address-valid strobe); map_addr out ADDR_W (tile map address); win_fine out 3 (fine row within tile); tile_x out MAP_W_LOG2 (current column).

Function
REQ-005 FSM states: IDLE (no y-hit this frame), ARMED (y-hit, waiting for x), ACTIVE (window fetching), DONE (window ended or disabled for the rest of the line).
REQ-006 Y-hit flag SHALL set on a cycle with win_en=1 and ly==wy, and SHALL clear only on frame_start or reset.
REQ-007 On line_start, the FSM SHALL go to ARMED if the y-hit flag is set or being set this cycle; otherwise it SHALL go to IDLE.
REQ-008 In ARMED, when px_valid=1, win_en=1, and the 9-bit sum {1'b0,px}+WX_OFFSET equals {1'b0,wx}: win_trigger SHALL pulse 1 cycle, the FSM SHALL go to ACTIVE, and tile_x SHALL load 0.
REQ-009 In ACTIVE, win_en=0 SHALL move the FSM to DONE on the next edge; win_active SHALL drop on that same edge.
REQ-010 win_active SHALL equal 1 only in the ACTIVE state.
REQ-011 Line counter win_line (8 bit) SHALL clear on frame_start. On line_start it SHALL increment by 1, mod 256, if the window was ACTIVE at any point during the previous line.
REQ-012 win_fine SHALL equal win_line[2:0].
REQ-013 Row SHALL be win_line[7:3] mod 2^MAP_H_LOG2, so the row wraps vertically.
REQ-014 fetch_req in ACTIVE SHALL produce fetch_ack exactly 1 cycle later, with map_addr valid and held until the next ack.
REQ-015 map_addr SHALL equal (map_sel ? BASE1 : BASE0) + (row << MAP_W_LOG2) + tile_x, truncated to ADDR_W bits. map_sel SHALL be sampled at the req cycle.
REQ-016 tile_x SHALL increment after each ack. At 2^MAP_W_LOG2-1 it SHALL wrap to 0 when CLAMP=0 and hold when CLAMP=1.
REQ-017 fetch_req outside ACTIVE SHALL be ignored: no ack is produced and map_addr is unchanged.
REQ-018 Simultaneous events, in priority order: reset > frame_start > line_start > trigger > fetch_req.
REQ-019 line_start together with a trigger condition: line_start wins and no trigger occurs.
REQ-020 frame_start together with line_start: win_line becomes 0 and the FSM goes to IDLE, unless ly==wy on that cycle, in which case it goes to ARMED.
REQ-021 A pending ack SHALL be cancelled if line_start or frame_start arrives in the ack cycle.

Reset
REQ-022 On reset_video2=1 at a clock edge, the following SHALL all reset: FSM=IDLE, y-hit=0, win_line=0, tile_x=0, map_addr=0, win_active=0, win_trigger=0, fetch_ack=0.
REQ-023 Reset asserted mid-line SHALL abort ACTIVE with no ack and no trigger emitted. The next frame_start SHALL restart normally.

Structure
REQ-024 The FSM state enum and the default BASE0/BASE1 constants SHALL live in the shared video package.
REQ-025 One sub-module, window_addr_calc, SHALL hold the combinational address composition and clamp/wrap logic. The FSM and counters SHALL remain in window_map_gen.

Verification
REQ-026 Frame_start, then ly==wy=16 with win_en=1, then line_start, then px=0..159 with wx=7 -> win_trigger pulses at px=0, win_active=1, tile_x=0, first ack yields map_addr=13'h1800.
REQ-027 Four consecutive lines active, then fetch at line 4 with map_sel=1 -> win_fine=4, row=0, map_addr=13'h1C00. At line 8 -> row=1, map_addr=13'h1C20.
REQ-028 33 fetches with CLAMP=0 -> tile_x wraps 31->0 and map_addr returns to base+row*32. Same stimulus with CLAMP=1 -> tile_x holds at 31.
REQ-029 win_en dropped mid-line in ACTIVE -> win_active=0 next cycle, FSM=DONE, later fetch_req gives no ack, and win_line still increments at the next line_start.
REQ-030 line_start coincident with the trigger condition -> no win_trigger pulse. frame_start coincident with line_start -> win_line=0.
REQ-031 reset_video2 asserted during a pending ack -> no fetch_ack and all outputs zero. Reset with MAP_W_LOG2=6, MAP_H_LOG2=6 -> address at row 1 equals base+64.
